// File: rtl/pc_pkg.sv
// pc_pkg: shared next-PC select encoding and default address constants for pc_gen.
package pc_pkg;
  typedef enum logic [2:0] {
    SEL_EXC,
    SEL_ERET,
    SEL_EX,
    SEL_ID,
    SEL_SEQ,
    SEL_HOLD
  } pc_sel_e;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC = 32'h0000_0080;
  localparam int DEF_INSTR_BYTES = 4;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] sp, tp;
  logic [PW:0] cnt;
  assign tp = sp - PW'(1);
  assign top = mem[tp];
  assign empty = cnt == '0;
  assign full = cnt == (PW+1)'(DEPTH);
  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
      cnt <= '0;
    end else if (push && pop && !empty) begin
      mem[tp] <= din;
    end else if (push) begin
      mem[sp] <= din;
      sp <= sp + PW'(1);
      cnt <= full ? cnt : cnt + (PW+1)'(1);
    end else if (pop && !empty) begin
      sp <= tp;
      cnt <= cnt - (PW+1)'(1);
    end
  end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: IF-stage fetch PC with prioritised redirects, EPC and alignment flag.
// Define PC_RAS_EN to add a return-address stack that predicts id_ret targets.
module pc_gen
  import pc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(DEF_EXC_VEC),
  parameter int INSTR_BYTES = DEF_INSTR_BYTES,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              exc_req,
  input  logic [ADDR_W-1:0] exc_pc,
  input  logic              eret,
  input  logic              ex_redirect,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              id_jump,
  input  logic [ADDR_W-1:0] id_target,
  input  logic              id_call,
  input  logic              id_ret,
  input  logic [ADDR_W-1:0] id_link,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] epc,
  output logic              flush,
  output logic              align_err
);
  localparam logic [ADDR_W-1:0] LO = ADDR_W'(INSTR_BYTES - 1);
  pc_sel_e sel;
  logic ras_hit;
  logic [ADDR_W-1:0] ras_top, raw, pc_next;
  logic align_next;
  assign sel = exc_req ? SEL_EXC :
               eret ? SEL_ERET :
               ex_redirect ? SEL_EX :
               (id_jump && !stall_if) ? SEL_ID :
               !stall_if ? SEL_SEQ : SEL_HOLD;
`ifdef PC_RAS_EN
  logic ras_empty, ras_full;
  pc_ras #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk),
    .rst(rst),
    .push(sel == SEL_ID && id_call),
    .pop(sel == SEL_ID && id_ret),
    .din(id_link),
    .top(ras_top),
    .empty(ras_empty),
    .full(ras_full)
  );
  assign ras_hit = id_ret && !ras_empty;
`else
  localparam int unused_depth = RAS_DEPTH;
  logic unused_ras;
  assign unused_ras = ^{id_call, id_ret, id_link};
  assign ras_hit = 1'b0;
  assign ras_top = '0;
`endif
  assign flush = exc_req | eret | ex_redirect;
  always_comb begin
    raw = sel == SEL_EX ? ex_target : ras_hit ? ras_top : id_target;
    align_next = (sel == SEL_EX || sel == SEL_ID) && (raw & LO) != '0;
    pc_next = sel == SEL_EXC ? EXC_VEC :
              sel == SEL_ERET ? epc :
              (sel == SEL_EX || sel == SEL_ID) ? (raw & ~LO) :
              sel == SEL_SEQ ? pc + ADDR_W'(INSTR_BYTES) : pc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VEC;
      epc <= '0;
      align_err <= 1'b0;
    end else begin
      pc <= pc_next;
      epc <= sel == SEL_EXC ? exc_pc : epc;
      align_err <= align_next;
    end
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vectors into a scoreboard queue; a monitor pops and checks each cycle.
module tb_pc_gen;
  logic clk = 0, rst, stall_if, exc_req, eret, ex_redirect, id_jump, id_call, id_ret;
  logic [31:0] exc_pc, ex_target, id_target, id_link, pc, epc;
  logic flush, align_err;
  int total = 0, bad = 0;
  typedef struct {
    string n;
    logic [31:0] p;
    logic [31:0] e;
    logic a;
    logic f;
  } exp_t;
  exp_t q[$];
  pc_gen dut (
    .clk(clk), .rst(rst), .stall_if(stall_if), .exc_req(exc_req), .exc_pc(exc_pc),
    .eret(eret), .ex_redirect(ex_redirect), .ex_target(ex_target), .id_jump(id_jump),
    .id_target(id_target), .id_call(id_call), .id_ret(id_ret), .id_link(id_link),
    .pc(pc), .epc(epc), .flush(flush), .align_err(align_err)
  );
  always #5 clk = ~clk;
  task automatic clr();
    {rst, stall_if, exc_req, eret, ex_redirect, id_jump, id_call, id_ret} = '0;
    {exc_pc, ex_target, id_target, id_link} = '0;
  endtask
  task automatic tick(string n, logic [31:0] p, logic [31:0] e, logic a, logic f);
    q.push_back('{n, p, e, a, f});
    @(negedge clk);
    clr();
  endtask
  task automatic chk(string n, string what, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s %s got=%h want=%h", n, what, got, want);
    end
  endtask
  initial begin
    exp_t x;
    logic f_now;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        x = q.pop_front();
        f_now = flush;
        @(posedge clk);
        #1;
        chk(x.n, "flush", {31'b0, f_now}, {31'b0, x.f});
        chk(x.n, "pc", pc, x.p);
        chk(x.n, "epc", epc, x.e);
        chk(x.n, "align_err", {31'b0, align_err}, {31'b0, x.a});
      end
    end
  end
  initial begin
    clr();
    @(negedge clk);
    rst = 1; tick("rst0", 32'h0, 32'h0, 0, 0);
    rst = 1; tick("rst1", 32'h0, 32'h0, 0, 0);
    tick("seq4", 32'h4, 32'h0, 0, 0);
    tick("seq8", 32'h8, 32'h0, 0, 0);
    tick("seqc", 32'hc, 32'h0, 0, 0);
    ex_redirect = 1; ex_target = 32'h100; tick("ex100", 32'h100, 32'h0, 0, 1);
    stall_if = 1; ex_redirect = 1; ex_target = 32'h400; tick("stall_ex", 32'h400, 32'h0, 0, 1);
    stall_if = 1; id_jump = 1; id_target = 32'h500; tick("stall_id", 32'h400, 32'h0, 0, 0);
    stall_if = 1; tick("stall_hold", 32'h400, 32'h0, 0, 0);
    ex_redirect = 1; ex_target = 32'h20; tick("ex20", 32'h20, 32'h0, 0, 1);
    exc_req = 1; exc_pc = 32'h1c; tick("exc", 32'h80, 32'h1c, 0, 1);
    tick("exc_seq", 32'h84, 32'h1c, 0, 0);
    eret = 1; tick("eret", 32'h1c, 32'h1c, 0, 1);
    exc_req = 1; eret = 1; exc_pc = 32'h44; tick("exc_eret", 32'h80, 32'h44, 0, 1);
    ex_redirect = 1; ex_target = 32'hffff_fffc; tick("ex_top", 32'hffff_fffc, 32'h44, 0, 1);
    tick("wrap", 32'h0, 32'h44, 0, 0);
    ex_redirect = 1; ex_target = 32'h203; tick("ex_mis", 32'h200, 32'h44, 1, 1);
    tick("mis_clr", 32'h204, 32'h44, 0, 0);
    id_jump = 1; id_target = 32'h302; tick("id_mis", 32'h300, 32'h44, 1, 0);
    id_jump = 1; id_ret = 1; id_target = 32'h300; tick("ret_norass", 32'h300, 32'h44, 0, 0);
    ex_redirect = 1; ex_target = 32'h600; id_jump = 1; id_target = 32'h700;
    tick("ex_over_id", 32'h600, 32'h44, 0, 1);
    exc_req = 1; exc_pc = 32'h90; ex_redirect = 1; ex_target = 32'h600;
    tick("exc_over_ex", 32'h80, 32'h90, 0, 1);
    rst = 1; ex_redirect = 1; ex_target = 32'h800; stall_if = 1;
    tick("rst_wins", 32'h0, 32'h0, 0, 1);
`ifdef PC_RAS_EN
    id_jump = 1; id_call = 1; id_link = 32'h10; id_target = 32'h1000; tick("call1", 32'h1000, 32'h0, 0, 0);
    id_jump = 1; id_call = 1; id_link = 32'h50; id_target = 32'h2000; tick("call2", 32'h2000, 32'h0, 0, 0);
    id_jump = 1; id_ret = 1; id_target = 32'h3000; tick("ret1", 32'h50, 32'h0, 0, 0);
    id_jump = 1; id_ret = 1; id_target = 32'h3000; tick("ret2", 32'h10, 32'h0, 0, 0);
    id_jump = 1; id_ret = 1; id_target = 32'h3000; tick("ret_empty", 32'h3000, 32'h0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      id_jump = 1; id_call = 1; id_link = 32'(i * 16); id_target = 32'h4000;
      tick("push", 32'h4000, 32'h0, 0, 0);
    end
    for (int i = 5; i >= 2; i--) begin
      id_jump = 1; id_ret = 1; id_target = 32'h5000;
      tick("pop", 32'(i * 16), 32'h0, 0, 0);
    end
    id_jump = 1; id_ret = 1; id_target = 32'h5000; tick("pop_empty", 32'h5000, 32'h0, 0, 0);
`else
    id_jump = 1; id_ret = 1; id_call = 1; id_link = 32'h10; id_target = 32'h300;
    tick("ret_tgt", 32'h300, 32'h0, 0, 0);
`endif
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised fetch-address generator for the pipelined core; next generation of the IF-stage PC register. Holds the fetch PC and selects the next PC by fixed priority: exception entry, exception return, EX-stage branch redirect, ID-stage jump, then sequential increment. Honours the IF stall, keeps an EPC register, and optionally predicts return targets with a small return-address stack (RAS).

Parameters:
ADDR_W, 32, PC/target width in bits.
RESET_VEC, 32'h0000_0000, PC value loaded on reset.
EXC_VEC, 32'h0000_0080, exception handler entry address.
INSTR_BYTES, 4, sequential increment; power of two; target low log2(INSTR_BYTES) bits forced to 0.
RAS_DEPTH, 4, RAS entries, power of two ≥2; used only with PC_RAS_EN.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-high.
stall_if  in  1  1 = hold PC (hazard unit / imem not ready).
exc_req  in  1  exception taken this cycle.
exc_pc  in  ADDR_W  PC of faulting instruction, captured into EPC.
eret  in  1  return from exception.
ex_redirect  in  1  EX branch resolved taken/mispredicted.
ex_target  in  ADDR_W  EX redirect target.
id_jump  in  1  ID decoded unconditional jump.
id_target  in  ADDR_W  ID jump target.
id_call  in  1  ID jump is a call (push link); ignored without PC_RAS_EN.
id_ret  in  1  ID jump is a return (use RAS top); ignored without PC_RAS_EN.
id_link  in  ADDR_W  return address to push on id_call.
pc  out  ADDR_W  current fetch PC.
epc  out  ADDR_W  exception PC register.
flush  out  1  combinational; 1 when exc_req, eret or ex_redirect is active.
align_err  out  1  registered pulse: accepted redirect target had nonzero low bits.

Behaviour:
- Reset (rst=1 at edge): pc=RESET_VEC, epc=0, align_err=0, RAS count/pointer=0. Reset wins over every other input, including mid-stall or mid-redirect.
- Next-PC priority, evaluated every cycle:
  1. exc_req: pc←EXC_VEC, epc←exc_pc.
  2. eret: pc←epc.
  3. ex_redirect: pc←ex_target.
  4. id_jump & ~stall_if: pc←id_target, or RAS top when id_ret with the RAS enabled and non-empty.
  5. ~stall_if: pc←pc+INSTR_BYTES, modulo 2^ADDR_W; FFFF_FFFC wraps to 0000_0000.
  6. Otherwise: hold.
- Priorities 1–3 override stall_if; the redirect is never lost. ID jump is ignored while stalled because ID re-presents it.
- Latency: one cycle; the selected value appears on pc after the next rising edge.
- exc_req and eret in the same cycle: exc_req wins, and epc is overwritten.
- Alignment: any redirect target (id/ex) has its low bits cleared before loading. align_err=1 for exactly one cycle after such a load when the raw target's low bits were nonzero; otherwise align_err=0.
- flush = exc_req | eret | ex_redirect, purely combinational, for younger-stage kill.

Optional Feature:
PC_RAS_EN.
- Defined:
  - RAS_DEPTH-entry circular stack.
  - On an accepted ID jump (not stalled, no higher-priority redirect):
    - id_call pushes id_link.
    - id_ret pops and redirects to the popped top.
    - id_call and id_ret together: pop then push; count unchanged, top replaced with id_link.
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty uses id_target; count stays 0.
  - No repair on flush.
- Undefined: no RAS storage; id_call and id_ret are ignored; returns use id_target.

Decomposition:
- Shared package pc_pkg: next-PC select enum (SEL_EXC, SEL_ERET, SEL_EX, SEL_ID, SEL_SEQ, SEL_HOLD), default RESET_VEC/EXC_VEC constants, INSTR_BYTES.
- One sub-module: pc_ras (circular stack, push/pop/top/empty/full), instantiated only under PC_RAS_EN.

Test Plan:
1. Reset: rst=1 for 2 cycles then 0, no stall → pc=0000_0000, then 4, 8, C on successive cycles; epc=0.
2. Stall plus redirect: pc=0x100, stall_if=1, ex_redirect=1, ex_target=0x400 → next pc=0x400, flush=1. With stall_if=1 and id_jump only → pc holds 0x400.
3. Exception and return: pc=0x20, exc_req=1, exc_pc=0x1C → pc=0x80, epc=0x1C. A later eret=1 → pc=0x1C. exc_req and eret together → pc=0x80.
4. Wrap and alignment: pc=FFFF_FFFC, free-running → pc=0000_0000. ex_target=0x203 → pc=0x200, align_err=1 for one cycle.
5. RAS (PC_RAS_EN): call id_link=0x10, then call id_link=0x50 → ret gives pc=0x50, next ret gives pc=0x10, a third ret gives id_target. Five pushes at depth 4 → pops return the newest 4 entries.
6. Without PC_RAS_EN: id_ret=1, id_target=0x300 → pc=0x300.
